// File: rtl/conv_pixel_streamer.sv
// Buffers one image and one kernel, then streams pixels in raster order.
// Optional zero-pad border: define CONV_STREAM_ZERO_PAD_EN.
module conv_pixel_streamer #(
    parameter int width       = 12,
    parameter int input_width = 8,
    parameter int im_dim      = 28,
    parameter int k_size      = 9
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              img_wr_en_i,
    input  logic [$clog2(im_dim*im_dim)-1:0]  img_wr_addr_i,
    input  logic [input_width-1:0]            img_wr_data_i,
    input  logic                              k_wr_en_i,
    input  logic [$clog2(k_size)-1:0]         k_idx_i,
    input  logic [width-1:0]                  k_data_i,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic                              conv_finished_i,
    output logic [width*k_size-1:0]           k_val_o,
    output logic [input_width-1:0]            pixel_o,
    output logic                              pix_data_valid_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int P  = im_dim * im_dim;
    localparam int AW = $clog2(P);
    localparam int KW = $clog2(k_size);
    localparam logic [KW-1:0] K_LAST = KW'(k_size - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_FIN, DONE} state_e;

    state_e                    state_q, state_d;
    logic [width*k_size-1:0]   k_val_q, k_val_d;
    logic [input_width-1:0]    mem [P];
    logic [input_width-1:0]    rd_q;
    logic [input_width-1:0]    pixel_q, pixel_d;
    logic                      rd_vld_q;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      rd_en, adv, clr, last, abort_hit;
    logic [AW-1:0]             rd_addr;
    logic [input_width-1:0]    rd_pix;

`ifdef CONV_STREAM_ZERO_PAD_EN
    localparam int D2 = im_dim + 2;
    localparam int CW = $clog2(D2);
    localparam logic [CW-1:0] C_LAST = CW'(D2 - 1);

    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic          border, rd_pad_q;

    assign last    = (row_q == C_LAST) && (col_q == C_LAST);
    assign border  = (row_q == '0) || (row_q == C_LAST) ||
                     (col_q == '0) || (col_q == C_LAST);
    assign rd_addr = border ? '0 :
                     AW'((int'(row_q) - 1) * im_dim + int'(col_q) - 1);
    assign rd_pix  = rd_pad_q ? '0 : rd_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == C_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q    <= '0;
            col_q    <= '0;
            rd_pad_q <= 1'b0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            rd_pad_q <= border;
        end
    end
`else
    localparam logic [AW-1:0] P_LAST = AW'(P - 1);

    logic [AW-1:0] cnt_q, cnt_d;

    assign last    = (cnt_q == P_LAST);
    assign rd_addr = cnt_q;
    assign rd_pix  = rd_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (adv) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

    // Counter saturates on the last pixel so it never wraps within a job.
    assign adv = rd_en && !last;

    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        clr       = 1'b0;
        done_d    = 1'b0;
        abort_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = STREAM;
            end
            STREAM: begin
                if (abort_i) begin
                    abort_hit = 1'b1;
                    clr       = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rd_en = 1'b1;
                    if (last) state_d = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (abort_i) begin
                    abort_hit = 1'b1;
                    clr       = 1'b1;
                    state_d   = IDLE;
                end else if (conv_finished_i) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        k_val_d = k_val_q;
        if (state_q == IDLE && k_wr_en_i && k_idx_i <= K_LAST)
            k_val_d[int'(k_idx_i)*width +: width] = k_data_i;
    end

    assign valid_d = rd_vld_q && !abort_hit;
    assign pixel_d = rd_vld_q ? rd_pix : pixel_q;
    assign busy_d  = (state_d != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            k_val_q  <= '0;
            rd_vld_q <= 1'b0;
            valid_q  <= 1'b0;
            pixel_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_val_q  <= k_val_d;
            rd_vld_q <= rd_en;
            valid_q  <= valid_d;
            pixel_q  <= pixel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Buffer has no reset so its contents survive a mid-job reset.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && img_wr_en_i)
            mem[img_wr_addr_i] <= img_wr_data_i;
        if (rd_en)
            rd_q <= mem[rd_addr];
    end

    assign k_val_o          = k_val_q;
    assign pixel_o          = pixel_q;
    assign pix_data_valid_o = valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// Randomized self-checking bench for conv_pixel_streamer.
// Model is rebuilt from the image/kernel arrays and raster rules.
module tb_conv_pixel_streamer;

    localparam int W  = 12;
    localparam int IW = 8;
    localparam int D  = 28;
    localparam int K  = 9;
    localparam int P  = D * D;
`ifdef CONV_STREAM_ZERO_PAD_EN
    localparam int NP = (D + 2) * (D + 2);
`else
    localparam int NP = P;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  img_wr_en_i = 1'b0;
    logic [$clog2(P)-1:0]  img_wr_addr_i = '0;
    logic [IW-1:0]         img_wr_data_i = '0;
    logic                  k_wr_en_i = 1'b0;
    logic [$clog2(K)-1:0]  k_idx_i = '0;
    logic [W-1:0]          k_data_i = '0;
    logic                  start_i = 1'b0;
    logic                  abort_i = 1'b0;
    logic                  conv_finished_i = 1'b0;
    logic [W*K-1:0]        k_val_o;
    logic [IW-1:0]         pixel_o;
    logic                  pix_data_valid_o;
    logic                  busy_o;
    logic                  done_o;

    conv_pixel_streamer #(
        .width(W), .input_width(IW), .im_dim(D), .k_size(K)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .img_wr_en_i(img_wr_en_i),
        .img_wr_addr_i(img_wr_addr_i),
        .img_wr_data_i(img_wr_data_i),
        .k_wr_en_i(k_wr_en_i),
        .k_idx_i(k_idx_i),
        .k_data_i(k_data_i),
        .start_i(start_i),
        .abort_i(abort_i),
        .conv_finished_i(conv_finished_i),
        .k_val_o(k_val_o),
        .pixel_o(pixel_o),
        .pix_data_valid_o(pix_data_valid_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] img  [P];
    logic [W-1:0]  kmod [K];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W*K-1:0] kvec();
        logic [W*K-1:0] v;
        v = '0;
        for (int i = 0; i < K; i++) v[i*W +: W] = kmod[i];
        return v;
    endfunction

    function automatic logic [IW-1:0] exp_pix(input int i);
`ifdef CONV_STREAM_ZERO_PAD_EN
        int r, c;
        r = i / (D + 2);
        c = i % (D + 2);
        if (r == 0 || c == 0 || r == D + 1 || c == D + 1) return '0;
        return img[(r - 1) * D + (c - 1)];
`else
        return img[i];
`endif
    endfunction

    task automatic wr_img(input int a, input logic [IW-1:0] d);
        img_wr_en_i   = 1'b1;
        img_wr_addr_i = a[$clog2(P)-1:0];
        img_wr_data_i = d;
        tick();
        img_wr_en_i   = 1'b0;
        img[a]        = d;
    endtask

    task automatic wr_k(input int idx, input logic [W-1:0] d);
        k_wr_en_i = 1'b1;
        k_idx_i   = idx[$clog2(K)-1:0];
        k_data_i  = d;
        tick();
        k_wr_en_i = 1'b0;
        if (idx < K) kmod[idx] = d;
    endtask

    // mode 0: full job, 1: abort after stop_at pixels, 2: reset after stop_at
    task automatic run_stream(input int stop_at, input int mode);
        start_i = 1'b1;
        tick();
        start_i     = 1'b0;
        img_wr_en_i = 1'b0;
        k_wr_en_i   = 1'b0;
        check("busy_start", busy_o, 1);
        tick();
        check("valid_n1", pix_data_valid_o, 0);
        for (int i = 0; i < NP; i++) begin
            tick();
            check("valid", pix_data_valid_o, 1);
            check("pixel", pixel_o, exp_pix(i));
            if (mode == 0 && i == 10) begin
                k_wr_en_i       = 1'b1;
                k_idx_i         = 4;
                k_data_i        = 12'hFFF;
                img_wr_en_i     = 1'b1;
                img_wr_addr_i   = '0;
                img_wr_data_i   = ~img[0];
                conv_finished_i = 1'b1;
                start_i         = 1'b1;
            end
            if (mode == 0 && i == 11) begin
                k_wr_en_i       = 1'b0;
                img_wr_en_i     = 1'b0;
                conv_finished_i = 1'b0;
                start_i         = 1'b0;
                check("kval_hold", k_val_o, kvec());
            end
            if (mode == 1 && i == stop_at - 1) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                check("abort_valid", pix_data_valid_o, 0);
                check("abort_busy", busy_o, 0);
                check("abort_done", done_o, 0);
                for (int j = 0; j < 3; j++) begin
                    tick();
                    check("abort_nodone", done_o, 0);
                    check("abort_idle_valid", pix_data_valid_o, 0);
                end
                return;
            end
            if (mode == 2 && i == stop_at - 1) begin
                #2 rst_ni = 1'b0;
                #1;
                check("rst_valid", pix_data_valid_o, 0);
                check("rst_pixel", pixel_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_kval", k_val_o, 0);
                for (int k = 0; k < K; k++) kmod[k] = '0;
                tick();
                rst_ni = 1'b1;
                tick();
                return;
            end
        end
        tick();
        check("valid_after", pix_data_valid_o, 0);
        check("pixel_hold", pixel_o, exp_pix(NP - 1));
        check("busy_wait", busy_o, 1);
    endtask

    task automatic finish_job();
        for (int j = 0; j < 5; j++) begin
            tick();
            check("wait_nodone", done_o, 0);
            check("wait_busy", busy_o, 1);
        end
        conv_finished_i = 1'b1;
        tick();
        conv_finished_i = 1'b0;
        check("done_pulse", done_o, 1);
        check("done_busy", busy_o, 1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("done_once", done_o, 0);
        check("idle_busy", busy_o, 0);
        tick();
        check("start_in_done_ign", busy_o, 0);
    endtask

    initial begin
        for (int k = 0; k < K; k++) kmod[k] = '0;
        tick();
        tick();
        check("rst_valid0", pix_data_valid_o, 0);
        check("rst_busy0", busy_o, 0);
        check("rst_done0", done_o, 0);
        check("rst_pixel0", pixel_o, 0);
        check("rst_kval0", k_val_o, 0);
        rst_ni = 1'b1;
        tick();

        for (int a = 0; a < P; a++) wr_img(a, IW'(a % 256));
        for (int k = 0; k < K; k++) wr_k(k, W'(k + 1));
        check("k0", k_val_o[11:0], 12'h001);
        check("k8", k_val_o[107:96], 12'h009);
        wr_k(9, 12'hABC);
        check("k_idx9_ign", k_val_o, kvec());
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_idle_noop", busy_o, 0);

        run_stream(0, 0);
        finish_job();

        for (int a = 0; a < P; a++) wr_img(a, IW'($urandom));
        for (int j = 0; j < 20; j++) begin
            wr_k(int'($urandom_range(0, 15)), W'($urandom));
            check("k_rand", k_val_o, kvec());
        end

        img_wr_en_i   = 1'b1;
        img_wr_addr_i = '0;
        img_wr_data_i = IW'($urandom);
        img[0]        = img_wr_data_i;
        run_stream(0, 0);
        finish_job();

        run_stream(100, 1);
        run_stream(0, 0);
        finish_job();

        run_stream(50, 2);
        check("post_rst_kval", k_val_o, 0);
        run_stream(0, 0);
        finish_job();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pixel_streamer.md
Name: conv_pixel_streamer

Overview:
- Source end of the convolution pixel interface.
- Buffers one square input image and one kernel, then streams pixels in raster order with a valid strobe to the filter FSM.
- Holds the kernel vector stable for the whole job, waits for the filter's finish indication, then reports done.
- Sits between the host/loader and the convolution block.

Parameters:
- width, 12, bit width of one kernel coefficient
- input_width, 8, bit width of one pixel
- im_dim, 28, image side length in pixels
- k_size, 9, number of kernel coefficients (3x3)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- img_wr_en_i  input  1  image buffer write strobe
- img_wr_addr_i  input  $clog2(im_dim*im_dim)  raster address of the written pixel
- img_wr_data_i  input  input_width  pixel value
- k_wr_en_i  input  1  kernel coefficient write strobe
- k_idx_i  input  $clog2(k_size)  coefficient index
- k_data_i  input  width  coefficient value
- start_i  input  1  single-cycle job start
- abort_i  input  1  cancel the running job
- conv_finished_i  input  1  finish flag from the filter FSM
- k_val_o  output  width*k_size  packed kernel; coefficient i at [i*width +: width]
- pixel_o  output  input_width  streamed pixel
- pix_data_valid_o  output  1  pixel_o valid this cycle
- busy_o  output  1  job in progress
- done_o  output  1  one-cycle job-complete pulse

Behaviour:
- Reset (asynchronous, active-low): state IDLE, all counters 0, k_val_o=0, pixel_o=0, pix_data_valid_o=0, busy_o=0, done_o=0. Image buffer contents are not reset.
- States: IDLE, STREAM, WAIT_FIN, DONE.
- IDLE:
  - img_wr_en_i writes the buffer synchronously.
  - k_wr_en_i updates coefficient k_idx_i of k_val_o on the next edge.
  - Kernel writes with k_idx_i >= k_size are ignored.
  - start_i -> STREAM; busy_o=1 from the next edge.
- In any state other than IDLE, image and kernel writes are ignored; k_val_o holds its value.
- Same-cycle start_i and a write in IDLE: the write is performed, then streaming starts; the written pixel is visible to the stream.
- STREAM:
  - Synchronous buffer read; pixel_o and pix_data_valid_o are registered together.
  - If start_i is sampled at edge N, pix_data_valid_o is high continuously from edge N+2 through edge N+1+P, where P = im_dim*im_dim (784 by default). No gaps.
  - Pixels are emitted in raster order, address 0 to P-1.
  - The pixel counter stops at P-1; it never wraps within a job.
- After the last pixel: pix_data_valid_o=0 and pixel_o holds its last value. State moves to WAIT_FIN.
- conv_finished_i asserted while in STREAM is ignored, and does not shorten the stream.
- WAIT_FIN: conv_finished_i=1 -> DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0 on the following edge, return to IDLE.
- A start_i in DONE is ignored.
- abort_i in STREAM or WAIT_FIN:
  - On the next edge: IDLE, pix_data_valid_o=0, busy_o=0, no done_o pulse, counters cleared.
  - abort_i has priority over conv_finished_i.
  - abort_i in IDLE is a no-op.
- start_i outside IDLE is ignored.
- Reset asserted mid-stream: outputs return to reset values immediately; the buffer is preserved.

Optional Feature:
- Macro: CONV_STREAM_ZERO_PAD_EN.
- Defined:
  - The stream emits a one-pixel zero border.
  - It contains (im_dim+2)*(im_dim+2) pixels (900 by default) in padded raster order.
  - Border positions output 0 with pix_data_valid_o=1; interior position (r+1,c+1) outputs buffer[r*im_dim+c].
  - Latency to the first valid is unchanged.
- Undefined: unpadded stream of im_dim*im_dim pixels as described above; no padding logic is present.

Test Plan:
- Load pixel[a]=a mod 256 for a=0..783, pulse start at edge N -> valid high edges N+2..N+785; pixel_o sequence 0,1,...,255,0,...,15 with no gaps; valid low afterwards; busy_o=1.
- Write coefficients 0x001..0x009 to idx 0..8, then start -> k_val_o[11:0]=0x001 and k_val_o[107:96]=0x009. A write of 0xFFF to idx 4 mid-stream leaves k_val_o unchanged. Writing idx 9 in IDLE leaves k_val_o unchanged.
- Pulse conv_finished_i during STREAM, then again 5 cycles after the last pixel -> first pulse ignored; done_o is a single pulse one cycle after the second; busy_o=0 after that; state IDLE.
- Assert abort_i at the 100th valid pixel -> valid=0 and busy_o=0 next edge, no done_o. A new start streams again from address 0.
- Assert reset at the 50th pixel, release, then start -> pixel_o begins at buffer[0]; buffer contents intact.
- With CONV_STREAM_ZERO_PAD_EN: all pixels = 0xAA -> 900 valid cycles; the first 30 and last 30 are 0; element 31 = 0xAA.
